// File: rtl/ex_mem_reg.sv
// ex_mem_reg: execute -> memory pipeline register.
//  Captures ALU result, store data, PC+2, destination and control bits from
//  the execute stage. Holds the entry while the data memory stalls. Squashes
//  the incoming entry on flush. Freezes once a halt or an alignment error
//  reaches the memory stage. Counts stalled valid cycles, saturating.
// Ports:
//  clk, rst (sync, active-low)
//  ex_*          execute-stage entry and control bits
//  flush         squash the entry entering this cycle
//  mem_stall     data memory busy, hold the MEM entry
//  align_err_m   alignment error for the current MEM entry
//  ex_ready      combinational advance-permit to execute
//  mem_*         registered MEM entry (control gated by valid)
//  mem_err       sticky alignment-error flag
//  halted        FSM is in HALTED
//  stall_cycles  saturating stall-cycle counter
module ex_mem_reg #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_aluOut,
  input  logic [DATA_W-1:0] ex_writeData,
  input  logic [DATA_W-1:0] ex_pc2,
  input  logic [REG_W-1:0]  ex_writeReg,
  input  logic              ex_memWrite,
  input  logic              ex_memRead,
  input  logic              ex_memAccess,
  input  logic              ex_memToReg,
  input  logic              ex_regWrite,
  input  logic              ex_halt,
  input  logic              flush,
  input  logic              mem_stall,
  input  logic              align_err_m,
  output logic              ex_ready,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_aluOut,
  output logic [DATA_W-1:0] mem_writeData,
  output logic [DATA_W-1:0] mem_pc2,
  output logic [REG_W-1:0]  mem_writeReg,
  output logic              mem_memWrite,
  output logic              mem_memRead,
  output logic              mem_memAccess,
  output logic              mem_memToReg,
  output logic              mem_regWrite,
  output logic              mem_halt,
  output logic              mem_err,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_e;

  typedef struct packed {
    logic memWrite;
    logic memRead;
    logic memAccess;
    logic memToReg;
    logic regWrite;
    logic halt;
  } ctrl_t;

  state_e            state_q, state_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] alu_q, alu_d, wd_q, wd_d, pc2_q, pc2_d;
  logic [REG_W-1:0]  wr_q, wr_d;
  ctrl_t             ctrl_q, ctrl_d, ex_ctrl;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic run, live, err_ev;

  assign ex_ctrl = '{memWrite: ex_memWrite, memRead: ex_memRead,
                     memAccess: ex_memAccess, memToReg: ex_memToReg,
                     regWrite: ex_regWrite, halt: ex_halt};

  assign run      = (state_q == RUN);
  assign ex_ready = run & ~mem_stall;
  assign live     = ex_valid & ~flush;
  // An error on the MEM entry wins over any incoming load so the faulting
  // entry stays visible for debug.
  assign err_ev   = run & valid_q & align_err_m & ~mem_stall;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    alu_d   = alu_q;
    wd_d    = wd_q;
    pc2_d   = pc2_q;
    wr_d    = wr_q;
    ctrl_d  = ctrl_q;
    err_d   = err_q;
    cnt_d   = cnt_q;

    if (err_ev) begin
      state_d         = HALTED;
      err_d           = 1'b1;
      ctrl_d.halt     = 1'b1;
      ctrl_d.memWrite = 1'b0;
      ctrl_d.memRead  = 1'b0;
    end else if (ex_ready) begin
      valid_d = live;
      alu_d   = ex_aluOut;
      wd_d    = ex_writeData;
      pc2_d   = ex_pc2;
      wr_d    = ex_writeReg;
      ctrl_d  = live ? ex_ctrl : '0;
      if (live && ex_halt) begin
        // Entering HALTED: suppress further memory side effects.
        state_d         = HALTED;
        ctrl_d.memWrite = 1'b0;
        ctrl_d.memRead  = 1'b0;
      end
    end

    if (run && mem_stall && valid_q && !(&cnt_q))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= RUN;
      valid_q <= 1'b0;
      alu_q   <= '0;
      wd_q    <= '0;
      pc2_q   <= '0;
      wr_q    <= '0;
      ctrl_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      alu_q   <= alu_d;
      wd_q    <= wd_d;
      pc2_q   <= pc2_d;
      wr_q    <= wr_d;
      ctrl_q  <= ctrl_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_valid     = valid_q;
  assign mem_aluOut    = alu_q;
  assign mem_writeData = wd_q;
  assign mem_pc2       = pc2_q;
  assign mem_writeReg  = wr_q;
  assign mem_memWrite  = ctrl_q.memWrite;
  assign mem_memRead   = ctrl_q.memRead;
  assign mem_memAccess = ctrl_q.memAccess;
  assign mem_memToReg  = ctrl_q.memToReg;
  assign mem_regWrite  = ctrl_q.regWrite;
  assign mem_halt      = ctrl_q.halt;
  assign mem_err       = err_q;
  assign halted        = (state_q == HALTED);
  assign stall_cycles  = cnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
module tb_ex_mem_reg;

  localparam int DW = 16;
  localparam int RW = 3;
  localparam int CW = 4;   // narrow counter so saturation is reachable

  logic clk = 1'b0;
  logic rst;
  logic ex_valid, flush, mem_stall, align_err_m;
  logic [DW-1:0] ex_aluOut, ex_writeData, ex_pc2;
  logic [RW-1:0] ex_writeReg;
  logic [5:0] ex_ctrl;  // {memWrite,memRead,memAccess,memToReg,regWrite,halt}

  logic ex_ready, mem_valid, mem_err, halted;
  logic [DW-1:0] mem_aluOut, mem_writeData, mem_pc2;
  logic [RW-1:0] mem_writeReg;
  logic mem_memWrite, mem_memRead, mem_memAccess, mem_memToReg, mem_regWrite, mem_halt;
  logic [CW-1:0] stall_cycles;

  int passed = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mem_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_aluOut(ex_aluOut),
    .ex_writeData(ex_writeData), .ex_pc2(ex_pc2), .ex_writeReg(ex_writeReg),
    .ex_memWrite(ex_ctrl[5]), .ex_memRead(ex_ctrl[4]), .ex_memAccess(ex_ctrl[3]),
    .ex_memToReg(ex_ctrl[2]), .ex_regWrite(ex_ctrl[1]), .ex_halt(ex_ctrl[0]),
    .flush(flush), .mem_stall(mem_stall), .align_err_m(align_err_m),
    .ex_ready(ex_ready), .mem_valid(mem_valid), .mem_aluOut(mem_aluOut),
    .mem_writeData(mem_writeData), .mem_pc2(mem_pc2), .mem_writeReg(mem_writeReg),
    .mem_memWrite(mem_memWrite), .mem_memRead(mem_memRead),
    .mem_memAccess(mem_memAccess), .mem_memToReg(mem_memToReg),
    .mem_regWrite(mem_regWrite), .mem_halt(mem_halt), .mem_err(mem_err),
    .halted(halted), .stall_cycles(stall_cycles));

  // Reference model: what the memory stage should be looking at.
  typedef struct packed {
    logic valid;
    logic [DW-1:0] alu, wd, pc2;
    logic [RW-1:0] wr;
    logic [5:0] ctrl;
    logic err, frozen;
    logic [CW-1:0] cnt;
  } mdl_t;

  mdl_t m;

  function automatic mdl_t predict(mdl_t c);
    mdl_t n = c;
    if (!rst) n = '0;
    else if (c.frozen) n = c;                       // only reset leaves
    else if (mem_stall) begin
      if (c.valid && c.cnt != {CW{1'b1}}) n.cnt = c.cnt + 1'b1;
    end else if (c.valid && align_err_m) begin
      n.err = 1'b1; n.frozen = 1'b1;
      n.ctrl[0] = 1'b1; n.ctrl[5:4] = 2'b00;
    end else begin
      n.valid = ex_valid && !flush;
      n.alu = ex_aluOut; n.wd = ex_writeData; n.pc2 = ex_pc2; n.wr = ex_writeReg;
      n.ctrl = n.valid ? ex_ctrl : 6'b0;
      if (n.valid && ex_ctrl[0]) begin n.frozen = 1'b1; n.ctrl[5:4] = 2'b00; end
    end
    return n;
  endfunction

  // Data fields are only meaningful when valid.
  function automatic logic [63:0] exp_vec();
    mdl_t e = m;
    if (!e.valid) begin e.alu = '0; e.wd = '0; e.pc2 = '0; e.wr = '0; end
    return e;
  endfunction

  function automatic logic [63:0] obs_vec();
    mdl_t o;
    o.valid = mem_valid;
    o.alu = m.valid ? mem_aluOut : '0;
    o.wd  = m.valid ? mem_writeData : '0;
    o.pc2 = m.valid ? mem_pc2 : '0;
    o.wr  = m.valid ? mem_writeReg : '0;
    o.ctrl = {mem_memWrite, mem_memRead, mem_memAccess, mem_memToReg, mem_regWrite, mem_halt};
    o.err = mem_err; o.frozen = halted; o.cnt = stall_cycles;
    return o;
  endfunction

  task automatic step();
    mdl_t n = predict(m);
    @(posedge clk); #1;
    m = n;
  endtask

  task automatic idle_inputs();
    ex_valid = 0; flush = 0; mem_stall = 0; align_err_m = 0;
    ex_aluOut = '0; ex_writeData = '0; ex_pc2 = '0; ex_writeReg = '0; ex_ctrl = '0;
  endtask

  task automatic rnd_ex(input bit allow_halt);
    ex_valid = 1'b1;
    ex_aluOut = DW'($urandom); ex_writeData = DW'($urandom); ex_pc2 = DW'($urandom);
    ex_writeReg = RW'($urandom);
    ex_ctrl = {5'($urandom), allow_halt ? ($urandom_range(0, 19) == 0) : 1'b0};
  endtask

  task automatic do_reset();
    rst = 0; step(); rst = 1; idle_inputs();
  endtask

  task automatic test_reset();
    rst = 0; mem_stall = 1; rnd_ex(1); flush = 0; align_err_m = 1;
    step(); rnd_ex(1); step();
    if (obs_vec() !== 64'h0) begin
      $display("FAIL reset_state: got %h exp 0", obs_vec());
    end else passed++;
    checks++;
    rst = 1; idle_inputs();
    #1;
    if (ex_ready !== 1'b1) $display("FAIL reset_ready: got %b exp 1", ex_ready);
    else passed++;
    checks++;
  endtask

  task automatic test_passthrough();
    do_reset();
    ex_valid = 1; ex_aluOut = 16'h1234; ex_writeData = 16'hBEEF; ex_pc2 = 16'h0042;
    ex_writeReg = 3'd5; ex_ctrl = 6'b000010;
    step();
    if ({mem_valid, mem_aluOut, mem_writeData, mem_writeReg, mem_regWrite, mem_halt}
        !== {1'b1, 16'h1234, 16'hBEEF, 3'd5, 1'b1, 1'b0})
      $display("FAIL passthrough: got %b %h %h %0d %b", mem_valid, mem_aluOut,
               mem_writeData, mem_writeReg, mem_regWrite);
    else passed++;
    checks++;
    if (obs_vec() !== exp_vec()) $display("FAIL passthrough_model: got %h exp %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    do_reset();
    rnd_ex(0); step();
    held = m.alu;
    for (int i = 0; i < 3; i++) begin
      mem_stall = 1; rnd_ex(0); #1;
      if (ex_ready !== 1'b0) $display("FAIL stall_ready: got %b exp 0", ex_ready);
      else passed++;
      checks++;
      step();
      if (mem_aluOut !== held || obs_vec() !== exp_vec())
        $display("FAIL stall_hold: got %h exp %h", obs_vec(), exp_vec());
      else passed++;
      checks++;
    end
    if (stall_cycles !== 4'd3) $display("FAIL stall_count: got %0d exp 3", stall_cycles);
    else passed++;
    checks++;
    mem_stall = 0; ex_aluOut = 16'h5A5A; step();
    if (mem_aluOut !== 16'h5A5A) $display("FAIL stall_release: got %h exp 5a5a", mem_aluOut);
    else passed++;
    checks++;
  endtask

  task automatic test_flush();
    do_reset();
    rnd_ex(0); ex_ctrl = 6'b100000; flush = 1; step();
    if ({mem_valid, mem_memWrite} !== 2'b00)
      $display("FAIL flush_squash: got valid=%b memWrite=%b exp 0 0", mem_valid, mem_memWrite);
    else passed++;
    checks++;
    flush = 0; rnd_ex(0); ex_ctrl = 6'b101010; step();
    mem_stall = 1; flush = 1; rnd_ex(0); step();
    if (obs_vec() !== exp_vec() || mem_valid !== 1'b1 || mem_memWrite !== 1'b1)
      $display("FAIL flush_stalled: got %h exp %h", obs_vec(), exp_vec());
    else passed++;
    checks++;
  endtask

  task automatic test_halt();
    logic [63:0] snap;
    do_reset();
    rnd_ex(0); ex_ctrl = 6'b110001; step();
    if ({halted, mem_halt, mem_memWrite, mem_memRead} !== 4'b1100)
      $display("FAIL halt_enter: got %b exp 1100", {halted, mem_halt, mem_memWrite, mem_memRead});
    else passed++;
    checks++;
    snap = obs_vec();
    for (int i = 0; i < 5; i++) begin
      rnd_ex(1); mem_stall = i[0]; flush = 0; #1;
      if (ex_ready !== 1'b0) $display("FAIL halt_ready: got %b exp 0", ex_ready);
      else passed++;
      checks++;
      step();
    end
    if (obs_vec() !== snap) $display("FAIL halt_frozen: got %h exp %h", obs_vec(), snap);
    else passed++;
    checks++;
    rst = 0; step(); rst = 1; idle_inputs(); #1;
    if ({halted, ex_ready} !== 2'b01) $display("FAIL halt_reset: got %b exp 01", {halted, ex_ready});
    else passed++;
    checks++;
  endtask

  task automatic test_align(input bit with_halt);
    do_reset();
    ex_valid = 1; ex_aluOut = 16'h0003; ex_ctrl = 6'b011000; step();
    rnd_ex(0); align_err_m = 1;
    if (with_halt) ex_ctrl[0] = 1'b1;
    step();
    if ({mem_err, halted, mem_memRead, mem_halt} !== 4'b1101)
      $display("FAIL align_err%0d: got %b exp 1101", with_halt, {mem_err, halted, mem_memRead, mem_halt});
    else passed++;
    checks++;
    if (mem_aluOut !== 16'h0003 || obs_vec() !== exp_vec())
      $display("FAIL align_keep%0d: got %h exp 0003", with_halt, mem_aluOut);
    else passed++;
    checks++;
  endtask

  task automatic test_saturate();
    do_reset();
    rnd_ex(0); step();
    mem_stall = 1;
    for (int i = 0; i < 20; i++) begin rnd_ex(0); step(); end
    if (stall_cycles !== 4'hF) $display("FAIL stall_saturate: got %0d exp 15", stall_cycles);
    else passed++;
    checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) != 0);
      rnd_ex(1);
      ex_valid    = ($urandom_range(0, 4) != 0);
      flush       = ($urandom_range(0, 4) == 0);
      mem_stall   = ($urandom_range(0, 9) < 3);
      align_err_m = ($urandom_range(0, 14) == 0);
      #1;
      if (ex_ready !== (!m.frozen && !mem_stall))
        $display("FAIL rand_ready[%0d]: got %b exp %b", i, ex_ready, !m.frozen && !mem_stall);
      else passed++;
      checks++;
      step();
      if (obs_vec() !== exp_vec())
        $display("FAIL rand_state[%0d]: got %h exp %h", i, obs_vec(), exp_vec());
      else passed++;
      checks++;
    end
  endtask

  initial begin
    m = '0;
    rst = 1; idle_inputs();
    @(negedge clk);
    test_reset();
    test_passthrough();
    test_stall();
    test_flush();
    test_halt();
    test_align(0);
    test_align(1);
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ex_mem_reg.md
Name: ex_mem_reg

Overview:
Pipeline register between the execute stage and the memory stage. It captures the execute results and the control bits, and it holds them while the data memory signals a stall. It squashes the entry on a flush and freezes the pipeline front once a halt or an alignment error reaches the memory stage. It also keeps a saturating count of memory-stall cycles for performance debug.

Parameters:
DATA_W, 16, width of the ALU result, store data and PC.
REG_W, 3, width of the destination register specifier.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  reset, synchronous, active-low (0 at posedge clk resets)
ex_valid  in  1  execute stage holds a real instruction
ex_aluOut  in  DATA_W  ALU result / memory address
ex_writeData  in  DATA_W  store data
ex_pc2  in  DATA_W  PC+2 of the instruction
ex_writeReg  in  REG_W  destination register
ex_memWrite, ex_memRead, ex_memAccess, ex_memToReg, ex_regWrite, ex_halt  in  1 each  control bits
flush  in  1  squash the instruction entering this cycle (branch mispredict)
mem_stall  in  1  data memory busy; the current MEM entry must be held
align_err_m  in  1  alignment error reported by the memory stage for the current entry
ex_ready  out  1  combinational; 1 = execute may advance into this register
mem_valid  out  1  registered valid bit of the MEM entry
mem_aluOut, mem_writeData, mem_pc2  out  DATA_W  registered data
mem_writeReg  out  REG_W  registered destination
mem_memWrite, mem_memRead, mem_memAccess, mem_memToReg, mem_regWrite, mem_halt  out  1 each  registered control, gated by valid
mem_err  out  1  sticky alignment-error flag
halted  out  1  1 when the FSM is in HALTED
stall_cycles  out  CNT_W  saturating count of stalled valid cycles

Behaviour:
- Reset (rst=0 at posedge): every registered output is 0, stall_cycles=0, FSM=RUN. Reset has priority over all other inputs, including reset mid-stall and reset in HALTED.
- FSM states: RUN, HALTED. There is no other way out of HALTED than reset.
- ex_ready = (FSM==RUN) & ~mem_stall. This is purely combinational.
- Load (ex_ready=1):
  - All data fields take their ex_* values.
  - mem_valid <= ex_valid & ~flush.
  - Each control output <= ex_X & ex_valid & ~flush, so a bubble carries all-zero control.
  - Data fields load even on a bubble; their value is don't-care.
- Hold (mem_stall=1 or FSM==HALTED): every mem_* output keeps its value.
  - flush is ignored during hold, because the held entry is older than the branch.
  - Upstream must keep its own entry stable while ex_ready=0.
- Latency: exactly one cycle from an ex_* input to the matching mem_* output when ex_ready=1.
- RUN->HALTED at posedge when either condition holds:
  - (a) a load captures ex_halt & ex_valid & ~flush; halted=1 from the same edge that sets mem_halt=1.
  - (b) mem_valid & align_err_m & ~mem_stall is sampled; mem_err<=1 on that edge.
- Simultaneous (a) and (b): HALTED; mem_err=1; the incoming halt instruction is NOT loaded, because the error entry is preserved.
- In HALTED:
  - mem_halt is forced to 1 so downstream memory dumps and disables.
  - mem_memWrite and mem_memRead are forced to 0, so no further memory side effects occur.
  - All other fields hold.
- mem_err: set as above, cleared only by reset.
- stall_cycles:
  - Increments by 1 on each posedge with mem_stall & mem_valid & FSM==RUN.
  - Saturates at 2^CNT_W-1 and does not wrap.
- Flush into a stalled cycle: no effect, and no state is remembered; the flush source re-asserts flush until ex_ready=1.

Test Plan:
1. Reset: hold rst=0 two cycles with random ex_* inputs -> all outputs 0, halted=0, ex_ready=1 after release.
2. Pass-through: ex_valid=1, ex_aluOut=0x1234, ex_writeData=0xBEEF, ex_writeReg=5, ex_regWrite=1 -> next cycle mem_aluOut=0x1234, mem_writeData=0xBEEF, mem_writeReg=5, mem_regWrite=1, mem_valid=1.
3. Stall: mem_stall=1 for 3 cycles with a valid entry and changing ex_* inputs -> ex_ready=0 and mem_* constant for 3 cycles, stall_cycles=3; the ex_* value present at the release edge loads on release.
4. Flush: ex_valid=1, ex_memWrite=1, flush=1, no stall -> mem_valid=0, mem_memWrite=0. Repeat with mem_stall=1 -> held entry unchanged.
5. Halt: load ex_halt=1 -> halted=1, mem_halt=1 on the same edge; ex_ready=0 thereafter; 5 further cycles of ex_valid=1 inputs leave outputs unchanged; rst=0 returns to RUN.
6. Alignment error: valid entry with mem_aluOut=0x0003, memRead=1, align_err_m=1 -> next edge mem_err=1, halted=1, mem_memRead=0, mem_halt=1. The same test with a simultaneous incoming ex_halt -> mem_aluOut stays 0x0003.
